melody_sequencer: RTL and testbench

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

---
 rtl/melody_pkg.sv | 36 +++
 rtl/melody_sequencer_beat_tick_gen.sv | 28 ++
 rtl/melody_sequencer.sv | 165 ++++++++++++++++
 tb/tb_melody_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: note codes, ROM entry layout,
// FSM state encoding and the note-code to one-hot select decoder.
package melody_pkg;

  localparam int unsigned ENTRY_W = 6;

  localparam logic [2:0] NOTE_REST = 3'd0;
  localparam logic [2:0] NOTE_DOI  = 3'd1;
  localparam logic [2:0] NOTE_RE   = 3'd2;
  localparam logic [2:0] NOTE_MI   = 3'd3;
  localparam logic [2:0] NOTE_FA   = 3'd4;
  localparam logic [2:0] NOTE_SO   = 3'd5;
  localparam logic [2:0] NOTE_END  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  function automatic logic [4:0] note_to_onehot(input logic [2:0] code);
    logic [4:0] oh;
    oh = '0;
    case (code)
      NOTE_DOI: oh = 5'b00001;
      NOTE_RE:  oh = 5'b00010;
      NOTE_MI:  oh = 5'b00100;
      NOTE_FA:  oh = 5'b01000;
      NOTE_SO:  oh = 5'b10000;
      default:  oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/melody_sequencer_beat_tick_gen.sv
// Beat prescaler: emits a one-cycle tick every i_len enabled cycles; i_restart
// synchronously clears the count so every note starts on a fresh beat.
module beat_tick_gen #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_restart,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == i_len - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || o_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Song-ROM melody sequencer driving a one-hot note select.
// Optional MELODY_TEMPO_EN adds a tempo[1:0] input (beat = BEAT_CYCLES >> tempo).
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned BEAT_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES  = 2500000,
  parameter int unsigned SONG_ID     = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
`ifdef MELODY_TEMPO_EN
  input  logic [1:0] tempo,
`endif
  output logic [4:0] select,
  output logic       busy,
  output logic [3:0] note_idx,
  output logic       done
);

  localparam int unsigned BEAT_W   = ($clog2(BEAT_CYCLES + 1) > 0) ? $clog2(BEAT_CYCLES + 1) : 1;
  localparam int unsigned GAP_W    = ($clog2(GAP_CYCLES + 1) > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [BEAT_W-1:0] BEAT_LEN = BEAT_W'(BEAT_CYCLES);

  localparam logic [ENTRY_W-1:0] E_END = {NOTE_END, 3'd0};

  // Entries are {note, dur}; listed from entry 15 down to entry 0.
  localparam logic [15:0][ENTRY_W-1:0] SONG0 = {
    {5{E_END}},
    {NOTE_DOI, 3'd2}, {NOTE_RE, 3'd0}, {NOTE_MI, 3'd0}, {NOTE_FA, 3'd0},
    {NOTE_SO, 3'd0}, {NOTE_REST, 3'd0}, {NOTE_SO, 3'd1}, {NOTE_FA, 3'd0},
    {NOTE_MI, 3'd0}, {NOTE_RE, 3'd0}, {NOTE_DOI, 3'd0}
  };
  localparam logic [15:0][ENTRY_W-1:0] SONG1 = {
    {14{E_END}}, {NOTE_MI, 3'd1}, {NOTE_DOI, 3'd0}
  };
  localparam logic [15:0][ENTRY_W-1:0] SONG2 = {
    {14{E_END}}, {NOTE_DOI, 3'd0}, {NOTE_REST, 3'd2}
  };
  localparam logic [15:0][ENTRY_W-1:0] SONG3 = {16{NOTE_DOI, 3'd0}};

  localparam logic [15:0][ENTRY_W-1:0] ROM =
    (SONG_ID == 1) ? SONG1 :
    (SONG_ID == 2) ? SONG2 :
    (SONG_ID == 3) ? SONG3 : SONG0;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_idx, w_idx_nxt, w_idx_inc;
  logic [2:0]       r_beat;
  logic [GAP_W-1:0] r_gap;
  logic [4:0]       r_sel, w_sel_nxt;
  logic             w_tick, w_advance, w_decide, w_last, w_note_end, w_gap_end;
  logic [BEAT_W-1:0] w_beat_len;

`ifdef MELODY_TEMPO_EN
  logic [1:0]        r_tempo;
  logic [BEAT_W-1:0] w_shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tempo <= '0;
    end else if (w_advance) begin
      r_tempo <= tempo;
    end
  end

  assign w_shifted  = BEAT_LEN >> r_tempo;
  assign w_beat_len = (w_shifted == '0) ? BEAT_W'(1) : w_shifted;
`else
  assign w_beat_len = BEAT_LEN;
`endif

  beat_tick_gen #(.CNT_W(BEAT_W)) u_beat (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (r_state == S_PLAY),
    .i_restart (w_advance || (w_state_nxt != S_PLAY)),
    .i_len     (w_beat_len),
    .o_tick    (w_tick)
  );

  assign w_idx_inc  = r_idx + 4'd1;
  assign w_last     = (r_idx == 4'd15) || (ROM[w_idx_inc][5:3] == NOTE_END);
  assign w_note_end = (r_state == S_PLAY) && w_tick && (r_beat == ROM[r_idx][2:0]);
  assign w_gap_end  = (r_state == S_GAP) && (r_gap == GAP_W'(GAP_LAST));

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_advance   = 1'b0;
    w_decide    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (ROM[0][5:3] == NOTE_END) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_PLAY;
            w_idx_nxt   = '0;
            w_advance   = 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (w_note_end) begin
          if (GAP_CYCLES > 0) w_state_nxt = S_GAP;
          else                w_decide    = 1'b1;
        end
      end
      S_GAP:   if (w_gap_end) w_decide = 1'b1;
      default: w_state_nxt = S_IDLE;
    endcase

    // loop_en only matters here, at the end of an entry
    if (w_decide) begin
      if (!w_last) begin
        w_state_nxt = S_PLAY;
        w_idx_nxt   = w_idx_inc;
        w_advance   = 1'b1;
      end else if (loop_en) begin
        w_state_nxt = S_PLAY;
        w_idx_nxt   = '0;
        w_advance   = 1'b1;
      end else begin
        w_state_nxt = S_DONE;
      end
    end

    if (stop) begin
      w_state_nxt = S_IDLE;
      w_advance   = 1'b0;
    end
    if (w_state_nxt == S_IDLE) w_idx_nxt = '0;

    w_sel_nxt = (w_state_nxt == S_PLAY) ? note_to_onehot(ROM[w_idx_nxt][5:3]) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_sel   <= '0;
      r_beat  <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_sel   <= w_sel_nxt;
      if (w_advance || (w_state_nxt != S_PLAY)) r_beat <= '0;
      else if (w_tick)                          r_beat <= r_beat + 3'd1;
      if ((r_state == S_GAP) && (w_state_nxt == S_GAP)) r_gap <= r_gap + 1'b1;
      else                                              r_gap <= '0;
    end
  end

  assign select   = r_sel;
  assign busy     = (r_state == S_PLAY) || (r_state == S_GAP);
  assign note_idx = r_idx;
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: three instances (test songs 1..3) at
// BEAT_CYCLES=10, GAP_CYCLES=2, checked cycle by cycle against fixed expectations.
module tb_melody_sequencer;

  logic       clk;
  logic       rst_n;
  logic [2:0] start, stop, loop_en;
  logic [4:0] sel [3];
  logic [3:0] idx [3];
  logic [2:0] busy, done;
`ifdef MELODY_TEMPO_EN
  logic [1:0] tempo3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    melody_sequencer #(
      .BEAT_CYCLES (10),
      .GAP_CYCLES  (2),
      .SONG_ID     (g + 1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[g]),
      .stop     (stop[g]),
      .loop_en  (loop_en[g]),
`ifdef MELODY_TEMPO_EN
      .tempo    ((g == 2) ? tempo3 : 2'd0),
`endif
      .select   (sel[g]),
      .busy     (busy[g]),
      .note_idx (idx[g]),
      .done     (done[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    step();
    start[k] = 1'b0;
  endtask

  task automatic pulse_stop(input int k);
    stop[k] = 1'b1;
    step();
    stop[k] = 1'b0;
  endtask

  task automatic expect_run(input int k, input string tag, input logic [4:0] s,
                            input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_sel"},  32'(sel[k]),  32'(s));
      check({tag, "_busy"}, 32'(busy[k]), 32'(b));
      check({tag, "_done"}, 32'(done[k]), 32'd0);
      step();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = '0;
    stop    = '0;
    loop_en = '0;
`ifdef MELODY_TEMPO_EN
    tempo3  = 2'd0;
`endif
    #12;
    check("rst_sel",  32'(sel[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_idx",  32'(idx[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    #10 rst_n = 1'b1;
    step();
    step();
    check("idle_hold", 32'(busy[0]), 32'd0);

    // A: doi(1 beat), mi(2 beats), END, no loop
    pulse_start(0);
    check("A_idx0", 32'(idx[0]), 32'd0);
    expect_run(0, "A_doi",  5'b00001, 1'b1, 10);
    expect_run(0, "A_gap1", 5'b00000, 1'b1, 2);
    check("A_idx1", 32'(idx[0]), 32'd1);
    expect_run(0, "A_mi",   5'b00100, 1'b1, 20);
    expect_run(0, "A_gap2", 5'b00000, 1'b1, 2);
    check("A_done", 32'(done[0]), 32'd1);
    check("A_done_sel", 32'(sel[0]), 32'd0);
    check("A_done_busy", 32'(busy[0]), 32'd0);
    step();
    check("A_done_end", 32'(done[0]), 32'd0);
    check("A_idle_busy", 32'(busy[0]), 32'd0);
    step();

    // B: same song looped, then stop
    loop_en[0] = 1'b1;
    pulse_start(0);
    expect_run(0, "B_doi",  5'b00001, 1'b1, 10);
    expect_run(0, "B_gap1", 5'b00000, 1'b1, 2);
    expect_run(0, "B_mi",   5'b00100, 1'b1, 20);
    expect_run(0, "B_gap2", 5'b00000, 1'b1, 2);
    check("B_loop_idx", 32'(idx[0]), 32'd0);
    expect_run(0, "B_doi2", 5'b00001, 1'b1, 4);
    pulse_stop(0);
    check("B_stop_sel",  32'(sel[0]), 32'd0);
    check("B_stop_busy", 32'(busy[0]), 32'd0);
    check("B_stop_done", 32'(done[0]), 32'd0);
    step();
    check("B_no_done", 32'(done[0]), 32'd0);
    loop_en[0] = 1'b0;

    // C: asynchronous reset in the middle of mi, then replay
    pulse_start(0);
    for (int i = 0; i < 17; i++) step();
    check("C_mi", 32'(sel[0]), 32'd4);
    rst_n = 1'b0;
    #1;
    check("C_rst_sel",  32'(sel[0]), 32'd0);
    check("C_rst_idx",  32'(idx[0]), 32'd0);
    check("C_rst_busy", 32'(busy[0]), 32'd0);
    #3 rst_n = 1'b1;
    step();
    step();
    check("C_stay_idle", 32'(busy[0]), 32'd0);
    pulse_start(0);
    check("C_replay_idx", 32'(idx[0]), 32'd0);
    expect_run(0, "C_replay", 5'b00001, 1'b1, 3);
    pulse_stop(0);

    // D: rest of 3 beats, start ignored while busy, start+stop resolves as stop
    pulse_start(1);
    expect_run(1, "D_rest_a", 5'b00000, 1'b1, 5);
    start[1] = 1'b1;
    expect_run(1, "D_rest_b", 5'b00000, 1'b1, 1);
    start[1] = 1'b0;
    expect_run(1, "D_rest_c", 5'b00000, 1'b1, 24);
    expect_run(1, "D_gap",    5'b00000, 1'b1, 2);
    check("D_idx1", 32'(idx[1]), 32'd1);
    expect_run(1, "D_doi",    5'b00001, 1'b1, 3);
    start[1] = 1'b1;
    stop[1]  = 1'b1;
    step();
    start[1] = 1'b0;
    stop[1]  = 1'b0;
    check("D_ss_busy", 32'(busy[1]), 32'd0);
    check("D_ss_sel",  32'(sel[1]), 32'd0);
    check("D_ss_done", 32'(done[1]), 32'd0);
    step();
    check("D_ss_idle", 32'(busy[1]), 32'd0);

    // E: 16 non-END entries, done after entry 15
    pulse_start(2);
    for (int e = 0; e < 16; e++) begin
      check($sformatf("E_idx%0d", e), 32'(idx[2]), 32'(e));
      expect_run(2, "E_doi", 5'b00001, 1'b1, 10);
      expect_run(2, "E_gap", 5'b00000, 1'b1, 2);
    end
    check("E_done", 32'(done[2]), 32'd1);
    step();
    check("E_done_end", 32'(done[2]), 32'd0);

`ifdef MELODY_TEMPO_EN
    // F: double tempo halves the beat, gap stays unscaled
    tempo3 = 2'd1;
    pulse_start(2);
    expect_run(2, "F_doi0", 5'b00001, 1'b1, 5);
    expect_run(2, "F_gap",  5'b00000, 1'b1, 2);
    check("F_idx1", 32'(idx[2]), 32'd1);
    expect_run(2, "F_doi1", 5'b00001, 1'b1, 5);
    pulse_stop(2);
    tempo3 = 2'd0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
